ctrl_seq: RTL
=============

Name: ctrl_seq

Overview:
- Control sequencer directly downstream of the instruction register in the 8-bit CPU.
- Consumes the 4-bit opcode that the IR presents on its instruction output.
- Steps a 6-state one-hot ring counter (T1..T6) and decodes the current T-state plus the opcode into the per-cycle control word.
- That control word drives the PC, MAR, RAM, IR, accumulator, B register, ALU and output register, including the IR's ir_in/ir_out strobes.

Parameters:
- OP_LDA, 4'b0000, load-accumulator opcode
- OP_ADD, 4'b0001, add opcode
- OP_SUB, 4'b0010, subtract opcode
- OP_JMP, 4'b0011, jump opcode (decoded only with CU_JMP_EN)
- OP_OUT, 4'b1110, output opcode
- OP_HLT, 4'b1111, halt opcode

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cu_en  input  1  sequencer enable; 0 freezes the T-state and zeroes the control word
- ir_ins  input  4  opcode from the instruction register
- t_state  output  6  one-hot T-state; bit0=T1 ... bit5=T6
- pc_inc  output  1  PC increment
- pc_out  output  1  PC drives bus
- pc_ld  output  1  PC loads from bus
- mar_in  output  1  MAR loads from bus
- ram_out  output  1  RAM drives bus
- ir_in  output  1  IR loads from bus
- ir_out  output  1  IR drives address field onto bus
- acc_in  output  1  accumulator load
- acc_out  output  1  accumulator drives bus
- b_in  output  1  B register load
- alu_sub  output  1  ALU subtract select (0 = add)
- alu_out  output  1  ALU drives bus
- out_in  output  1  output register load
- halt  output  1  CPU halted

Behaviour:
Clocking and reset
- One clock; reset is asynchronous and active-low.
- While rst_n=0: t_state=6'b000001 (T1), halt=0, all control outputs 0, regardless of clk.
- After release, the first rising edge with cu_en=1 moves the state T1->T2.

T-state sequencing
- Advance on each rising edge with cu_en=1 and halt=0: T1->T2->...->T6->T1.
- cu_en=0: state holds; all control outputs 0; halt holds its value.

Control word decode
- Control outputs are a combinational decode of (t_state, ir_ins, halt, cu_en).
- Each strobe is valid for the whole cycle and is acted on by the datapath at the closing rising edge.
- At most one bus driver asserted in any cycle.
- Fetch, all opcodes:
  - T1: pc_out, mar_in.
  - T2: pc_inc.
  - T3: ram_out, ir_in.
- ir_ins is sampled only in T4..T6. The IR captures it at the T3->T4 edge.
- Execute steps:
  - LDA: T4 ir_out, mar_in. T5 ram_out, acc_in. T6 none.
  - ADD: T4 ir_out, mar_in. T5 ram_out, b_in. T6 alu_out, acc_in.
  - SUB: as ADD, but T6 also asserts alu_sub.
  - OUT: T4 acc_out, out_in. T5, T6 none.
  - HLT: T4 halt set (combinationally from T4 & HLT).
- Halt behaviour:
  - halt is registered at the next edge and remains 1 until reset.
  - The state stays at T4; all other control outputs stay 0 while halted.
  - cu_en has no effect while halted.
- Undefined opcodes (and JMP without the macro): T4..T6 assert nothing; the sequence continues to T1.
- pc_ld is always 0 unless CU_JMP_EN is defined.

Boundary cases
- Reset asserted in any state, including while halted: immediate return to T1 with halt=0.
- cu_en falling in T6: hold at T6; resume to T1 on re-enable.
- An ir_ins change during T4..T6 follows the decode immediately. The IR guarantees stability, so the sequencer adds no latch.

Optional Feature:
- Macro CU_JMP_EN.
- Defined: OP_JMP is decoded as T4 ir_out, pc_ld; T5, T6 none.
- Undefined: OP_JMP is treated as NOP; pc_ld is tied 0. The port list is unchanged.

Test Plan:
1. Reset, then cu_en=1, ir_ins=4'b0000, 6 clocks.
   - t_state goes 000001, 000010, 000100, 001000, 010000, 100000, 000001.
   - T1 pc_out=mar_in=1; T2 pc_inc=1; T3 ram_out=ir_in=1; T4 ir_out=mar_in=1; T5 ram_out=acc_in=1.
2. ir_ins=4'b0010 at T4.
   - T5 ram_out=b_in=1.
   - T6 alu_out=acc_in=alu_sub=1; alu_sub=0 in every other state.
3. ir_ins=4'b1110 through a full sequence.
   - T4 acc_out=out_in=1; T5, T6 all control outputs 0; returns to T1.
4. ir_ins=4'b1111 at T4.
   - halt=1 from T4 onward; t_state stays 001000 for 10 clocks with other outputs 0.
   - Assert rst_n=0 mid-cycle: halt=0 and t_state=000001 immediately, before the next edge.
5. cu_en=0 for 3 clocks during T2.
   - t_state stays 000010 and pc_inc=0; after cu_en=1, pc_inc=1 for one cycle, then T3.
6. ir_ins=4'b0011 at T4.
   - With CU_JMP_EN: ir_out=pc_ld=1.
   - Without: all control outputs 0 in T4..T6 and pc_ld never 1.

Source files
------------

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - 6-state one-hot control sequencer for the 8-bit CPU (optional jump decode: CU_JMP_EN)
module ctrl_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cu_en,
    input  logic [3:0] ir_ins,
    output logic [5:0] t_state,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_ld,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       acc_in,
    output logic       acc_out,
    output logic       b_in,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_in,
    output logic       halt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
`ifdef CU_JMP_EN
    localparam logic [3:0] OP_JMP = 4'b0011;
`endif
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e state_q;
    logic     halt_q;
    logic     active;
    logic     hlt_dec;

    // rst_n gates the decode so the control word is quiet throughout reset, not only after the edge
    assign active  = rst_n & cu_en & ~halt_q;
    assign hlt_dec = active & (state_q == T4) & (ir_ins == OP_HLT);
    assign halt    = halt_q | hlt_dec;
    assign t_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T1;
            halt_q  <= 1'b0;
        end else if (hlt_dec) begin
            halt_q <= 1'b1;
        end else if (active) begin
            case (state_q)
                T1:      state_q <= T2;
                T2:      state_q <= T3;
                T3:      state_q <= T4;
                T4:      state_q <= T5;
                T5:      state_q <= T6;
                default: state_q <= T1;
            endcase
        end
    end

    always_comb begin
        pc_inc  = 1'b0;
        pc_out  = 1'b0;
        pc_ld   = 1'b0;
        mar_in  = 1'b0;
        ram_out = 1'b0;
        ir_in   = 1'b0;
        ir_out  = 1'b0;
        acc_in  = 1'b0;
        acc_out = 1'b0;
        b_in    = 1'b0;
        alu_sub = 1'b0;
        alu_out = 1'b0;
        out_in  = 1'b0;
        if (active) begin
            case (state_q)
                T1: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                end
                T4: begin
                    case (ir_ins)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_OUT: begin
                            acc_out = 1'b1;
                            out_in  = 1'b1;
                        end
`ifdef CU_JMP_EN
                        OP_JMP: begin
                            ir_out = 1'b1;
                            pc_ld  = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                T5: begin
                    case (ir_ins)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            acc_in  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (ir_ins == OP_ADD || ir_ins == OP_SUB) begin
                        alu_out = 1'b1;
                        acc_in  = 1'b1;
                        alu_sub = (ir_ins == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
